data_memory_arbiter: RTL and testbench
======================================

Name: data_memory_arbiter

Overview:
- Two-port round-robin arbiter and sequencer in front of the single-port data_memory block (combinational read, level-sensitive write on control_write).
- Requester 0 is the pipeline MEM stage; requester 1 is the debug/DMA loader.
- Serialises accesses, drives the memory port from registered values and returns registered read data with a completion pulse.

Parameters:
- W, 3, MSB index of address and data (widths are W+1), matching data_memory's w.
- CNT_W, 16, width of the grant counters (optional feature only).

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- p0_req  input  1  requester 0 access request; held until p0_gnt
- p0_we  input  1  requester 0: 1 = write, 0 = read
- p0_addr  input  W+1  requester 0 address
- p0_wdata  input  W+1  requester 0 write data
- p0_gnt  output  1  one-cycle pulse: p0 request accepted, payload captured
- p0_done  output  1  one-cycle pulse: p0 access complete
- p0_rdata  output  W+1  p0 read data, valid when p0_done for a read
- p1_req, p1_we, p1_addr, p1_wdata, p1_gnt, p1_done, p1_rdata  same as p0, for requester 1
- mem_address  output  W+1  to data_memory address
- mem_write_data  output  W+1  to data_memory write_data
- mem_control_write  output  1  to data_memory control_write
- mem_read_data  input  W+1  from data_memory read_data

Behaviour:
- Clock and reset: one clock domain, clk. reset is asynchronous and active-high.
- Reset values:
  - state = IDLE, all outputs 0, last_grant = 1.
  - mem_control_write drops to 0 immediately on reset assertion, not at the next edge.
- FSM states: IDLE, ACCESS, RESP.
  - IDLE: if any req, select a winner and register its we/addr/wdata and id into the access registers; go to ACCESS. Otherwise stay.
  - ACCESS: the selected port's gnt = 1 for exactly this cycle. mem_address and mem_write_data come from the access registers; mem_control_write = registered we. On the exit edge, latch mem_read_data into the winner's rdata when it is a read; go to RESP.
  - RESP: winner's done = 1 for one cycle; mem_control_write = 0; go to IDLE.
- Timing:
  - Request seen in IDLE at edge T gives gnt in T+1 and done in T+2. Read latency is 2 cycles from acceptance.
  - Throughput is 1 access per 3 cycles.
- Request rules:
  - Requester must hold req and payload stable until it sees gnt.
  - Requester may drop req or present a new request the cycle after gnt.
  - req still high during RESP is re-arbitrated in the following IDLE.
- Arbitration:
  - Single requester: that requester wins.
  - Both requesting: the port != last_grant wins; last_grant updates on every win.
  - Consequence: the first tie after reset goes to port 0, and under continuous contention grants alternate 0,1,0,1.
- Memory port outside ACCESS:
  - mem_address and mem_write_data hold their last value.
  - mem_control_write is 0 in all states other than ACCESS, so data_memory never sees a spurious write.
- rdata outputs:
  - Each port's rdata holds its last read value until that port's next read completes.
  - Writes do not change rdata.
  - The non-winning port's rdata and done are untouched.
- Reset mid-operation: the FSM aborts to IDLE, no gnt/done is issued for the aborted access, and rdata clears to 0. A write aborted in ACCESS may or may not have updated memory; the requester must reissue.
- No X propagation: an undriven req is treated as 0 by the bench; RTL needs no special handling.

Optional Feature:
- Macro: DATA_MEMORY_ARBITER_STATS_EN.
- When defined, adds:
  - input stats_clear (1 bit).
  - outputs p0_grant_count and p1_grant_count (CNT_W bits each).
- Counter behaviour:
  - Each counter increments by 1 in every cycle its port's gnt is high, saturating at all-ones.
  - stats_clear synchronously zeroes both counters and takes priority over a same-cycle increment.
  - reset zeroes both counters.
- When undefined, these ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Single write then read:
  - p0 writes addr 5, data 0xA, then reads addr 5.
  - Required: p0_gnt one cycle after each req; mem_control_write high only in the write's ACCESS cycle; p0_done with p0_rdata = 0xA two cycles after the read's acceptance.
- Tie after reset:
  - p0 and p1 both assert read req in the same cycle.
  - Required: p0 granted first; p1 granted 3 cycles later; grants alternate for 4 further held requests (0,1,0,1).
- Isolation:
  - p1 writes 0x3 to addr 2 while p0 is idle.
  - Required: p0_rdata and p0_done unchanged; a later p1 read of addr 2 returns 0x3.
- Back-to-back:
  - p0 holds req for 3 consecutive reads of addr 0, 1, 2 (preloaded 0x1, 0x2, 0x4).
  - Required: p0_done every 3 cycles with rdata 0x1, 0x2, 0x4.
- Reset mid-operation:
  - Assert reset during the ACCESS cycle of a p1 write.
  - Required: mem_control_write = 0 immediately; no p1_gnt/p1_done follows; state IDLE; p0 tie wins first after release.
- Stats (with DATA_MEMORY_ARBITER_STATS_EN defined):
  - 5 p0 grants and 2 p1 grants.
  - Required: counts read 5 and 2; stats_clear pulsed concurrent with a grant leaves both counters at 0.

Source files
------------

// File: rtl/data_memory_arbiter.sv
// Round-robin arbiter and access sequencer for two requesters sharing the single-port data_memory.
// Optional grant counters are enabled by defining DATA_MEMORY_ARBITER_STATS_EN.
module data_memory_arbiter #(
  parameter int W     = 3,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             p0_req,
  input  logic             p0_we,
  input  logic [W:0]       p0_addr,
  input  logic [W:0]       p0_wdata,
  output logic             p0_gnt,
  output logic             p0_done,
  output logic [W:0]       p0_rdata,
  input  logic             p1_req,
  input  logic             p1_we,
  input  logic [W:0]       p1_addr,
  input  logic [W:0]       p1_wdata,
  output logic             p1_gnt,
  output logic             p1_done,
  output logic [W:0]       p1_rdata,
`ifdef DATA_MEMORY_ARBITER_STATS_EN
  input  logic             stats_clear,
  output logic [CNT_W-1:0] p0_grant_count,
  output logic [CNT_W-1:0] p1_grant_count,
`endif
  output logic [W:0]       mem_address,
  output logic [W:0]       mem_write_data,
  output logic             mem_control_write,
  input  logic [W:0]       mem_read_data
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t     state, state_nxt;
  logic       acc_id, acc_we, last_grant;
  logic [W:0] acc_addr, acc_wdata;
  logic       any_req, win_id;

  assign any_req = p0_req | p1_req;
  // On a tie the port that did not win last time takes the grant.
  assign win_id  = (p0_req && p1_req) ? ~last_grant : p1_req;

  // Outputs decode straight from state so write enable drops the instant reset asserts.
  always_comb begin
    state_nxt         = state;
    p0_gnt            = 1'b0;
    p1_gnt            = 1'b0;
    p0_done           = 1'b0;
    p1_done           = 1'b0;
    mem_control_write = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) state_nxt = ACCESS;
      end
      ACCESS: begin
        p0_gnt            = ~acc_id;
        p1_gnt            = acc_id;
        mem_control_write = acc_we;
        state_nxt         = RESP;
      end
      RESP: begin
        p0_done   = ~acc_id;
        p1_done   = acc_id;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      acc_id     <= 1'b0;
      acc_we     <= 1'b0;
      acc_addr   <= '0;
      acc_wdata  <= '0;
      last_grant <= 1'b1;
      p0_rdata   <= '0;
      p1_rdata   <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && any_req) begin
        acc_id     <= win_id;
        acc_we     <= win_id ? p1_we    : p0_we;
        acc_addr   <= win_id ? p1_addr  : p0_addr;
        acc_wdata  <= win_id ? p1_wdata : p0_wdata;
        last_grant <= win_id;
      end
      if (state == ACCESS && !acc_we) begin
        if (acc_id) p1_rdata <= mem_read_data;
        else        p0_rdata <= mem_read_data;
      end
    end
  end

  // Access registers only load on a win, so the memory port holds its last value otherwise.
  assign mem_address    = acc_addr;
  assign mem_write_data = acc_wdata;

`ifdef DATA_MEMORY_ARBITER_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p0_grant_count <= '0;
      p1_grant_count <= '0;
    end else if (stats_clear) begin
      p0_grant_count <= '0;
      p1_grant_count <= '0;
    end else begin
      if (p0_gnt && !(&p0_grant_count)) p0_grant_count <= p0_grant_count + 1'b1;
      if (p1_gnt && !(&p1_grant_count)) p1_grant_count <= p1_grant_count + 1'b1;
    end
  end
`else
  logic [CNT_W-1:0] stats_unused;
  assign stats_unused = '0;
`endif

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Self-checking bench for data_memory_arbiter: directed scenarios plus random traffic against a
// transaction-level model (arbitration rule, 3-cycle access slots, memory array, per-port rdata).
module tb_data_memory_arbiter;
  localparam int W = 3;

  logic         clk = 1'b0;
  logic         reset;
  logic         p0_req, p0_we, p1_req, p1_we;
  logic [W:0]   p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic         p0_gnt, p0_done, p1_gnt, p1_done;
  logic [W:0]   p0_rdata, p1_rdata;
  logic [W:0]   mem_address, mem_write_data, mem_read_data;
  logic         mem_control_write;
`ifdef DATA_MEMORY_ARBITER_STATS_EN
  logic         stats_clear;
  logic [15:0]  p0_grant_count, p1_grant_count;
`endif

  data_memory_arbiter #(.W(W), .CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_done(p0_done), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_done(p1_done), .p1_rdata(p1_rdata),
`ifdef DATA_MEMORY_ARBITER_STATS_EN
    .stats_clear(stats_clear), .p0_grant_count(p0_grant_count), .p1_grant_count(p1_grant_count),
`endif
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_control_write(mem_control_write), .mem_read_data(mem_read_data)
  );

  always #5 clk = ~clk;

  // Stand-in for data_memory: combinational read, write committed while control_write is high.
  logic [W:0] mem_arr [16];
  assign mem_read_data = mem_arr[mem_address];
  always @(posedge clk) if (mem_control_write) mem_arr[mem_address] <= mem_write_data;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: one access slot at a time, each occupying three edges.
  int         cyc = 0;
  int         free_at = 0;
  bit         m_last = 1'b1;
  bit         pend_v = 1'b0;
  bit         pend_port, pend_we;
  logic [W:0] pend_addr, pend_wdata;
  int         pend_edge;
  logic [W:0] m_mem [16];
  logic [W:0] m_rdata [2];
  bit         exp_gnt [2];
  bit         exp_done [2];

  task automatic set_port(input bit p, input bit rq, input bit we, input logic [W:0] a,
                          input logic [W:0] d);
    if (p) begin p1_req = rq; p1_we = we; p1_addr = a; p1_wdata = d; end
    else   begin p0_req = rq; p0_we = we; p0_addr = a; p0_wdata = d; end
  endtask

  task automatic step();
    bit         r [2];
    bit         we [2];
    logic [W:0] a [2];
    logic [W:0] d [2];
    bit         win;
    bit         ecw;
    r[0] = p0_req; we[0] = p0_we; a[0] = p0_addr; d[0] = p0_wdata;
    r[1] = p1_req; we[1] = p1_we; a[1] = p1_addr; d[1] = p1_wdata;
    @(posedge clk); #1;
    cyc++;
    exp_gnt[0] = 0; exp_gnt[1] = 0; exp_done[0] = 0; exp_done[1] = 0;
    ecw = 0;
    if (pend_v && cyc == pend_edge + 1) begin
      exp_done[pend_port] = 1;
      if (pend_we) m_mem[pend_addr] = pend_wdata;
      else         m_rdata[pend_port] = m_mem[pend_addr];
      pend_v = 0;
    end
    if (cyc >= free_at && (r[0] || r[1])) begin
      win = (r[0] && r[1]) ? !m_last : r[1];
      m_last = win;
      pend_v = 1; pend_port = win; pend_we = we[win];
      pend_addr = a[win]; pend_wdata = d[win]; pend_edge = cyc;
      free_at = cyc + 3;
      exp_gnt[win] = 1;
      ecw = pend_we;
    end
    check_eq("p0_gnt", p0_gnt, exp_gnt[0]);
    check_eq("p1_gnt", p1_gnt, exp_gnt[1]);
    check_eq("p0_done", p0_done, exp_done[0]);
    check_eq("p1_done", p1_done, exp_done[1]);
    check_eq("mem_cw", mem_control_write, ecw);
    check_eq("p0_rdata", p0_rdata, m_rdata[0]);
    check_eq("p1_rdata", p1_rdata, m_rdata[1]);
    if (exp_gnt[0] || exp_gnt[1]) begin
      check_eq("mem_addr", mem_address, pend_addr);
      if (ecw) check_eq("mem_wdata", mem_write_data, pend_wdata);
    end
  endtask

  task automatic model_reset();
    pend_v = 0; free_at = 0; m_last = 1'b1;
    m_rdata[0] = '0; m_rdata[1] = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    set_port(0, 0, 0, '0, '0);
    set_port(1, 0, 0, '0, '0);
`ifdef DATA_MEMORY_ARBITER_STATS_EN
    stats_clear = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
    check_eq("rst_gnt", {p1_gnt, p0_gnt}, 2'b00);
    check_eq("rst_done", {p1_done, p0_done}, 2'b00);
    check_eq("rst_cw", mem_control_write, 1'b0);
    check_eq("rst_rdata", {p1_rdata, p0_rdata}, '0);
  endtask

  // Issue one access, wait (bounded) for its grant, then run through done back to idle.
  task automatic do_req(input bit p, input bit we, input logic [W:0] a, input logic [W:0] d,
                        output int lat);
    bit got = 0;
    lat = 0;
    set_port(p, 1, we, a, d);
    for (int i = 0; i < 20 && !got; i++) begin
      step();
      lat++;
      got = exp_gnt[p];
    end
    if (!got) check_eq("gnt_timeout", 0, 1);
    set_port(p, 0, we, a, d);
    step();
    step();
  endtask

  initial begin
    int         lat, n, prev;
    logic [W:0] b2b_vals [3];
    b2b_vals[0] = 4'h1; b2b_vals[1] = 4'h2; b2b_vals[2] = 4'h4;
    for (int i = 0; i < 16; i++) begin mem_arr[i] = '0; m_mem[i] = '0; end
    do_reset();
    step();

    // Single write then read on p0.
    do_req(0, 1, 4'd5, 4'hA, lat);
    check_eq("wr_gnt_lat", lat, 1);
    do_req(0, 0, 4'd5, 4'h0, lat);
    check_eq("rd_gnt_lat", lat, 1);
    check_eq("rd_a5", p0_rdata, 4'hA);

    // Isolation: p1 write leaves p0 untouched, p1 reads it back.
    do_req(1, 1, 4'd2, 4'h3, lat);
    check_eq("iso_p0_rdata", p0_rdata, 4'hA);
    do_req(1, 0, 4'd2, 4'h0, lat);
    check_eq("iso_p1_rdata", p1_rdata, 4'h3);
    check_eq("iso_p0_keep", p0_rdata, 4'hA);

    // Back-to-back reads on p0.
    do_req(1, 1, 4'd0, 4'h1, lat);
    do_req(1, 1, 4'd1, 4'h2, lat);
    do_req(1, 1, 4'd2, 4'h4, lat);
    set_port(0, 1, 0, 4'd0, '0);
    prev = 0;
    for (int k = 0; k < 3; k++) begin
      n = 0;
      do begin step(); n++; end while (!exp_gnt[0] && n < 10);
      if (k == 2) p0_req = 1'b0;
      else        p0_addr = 4'(k + 1);
      step();
      check_eq("b2b_done", p0_done, 1'b1);
      check_eq("b2b_rdata", p0_rdata, b2b_vals[k]);
      if (k > 0) check_eq("b2b_period", cyc - prev, 3);
      prev = cyc;
    end
    step();

    // Tie after reset: alternation starting with p0.
    do_reset();
    set_port(0, 1, 0, 4'd3, '0);
    set_port(1, 1, 0, 4'd4, '0);
    for (int k = 0; k < 6; k++) begin
      n = 0;
      do begin step(); n++; end while (!(exp_gnt[0] || exp_gnt[1]) && n < 10);
      check_eq("tie_order", {p1_gnt, p0_gnt}, (k % 2) ? 2'b10 : 2'b01);
      check_eq("tie_gap", n, (k == 0) ? 1 : 3);
    end
    set_port(0, 0, 0, '0, '0);
    set_port(1, 0, 0, '0, '0);
    repeat (3) step();

    // Reset during the ACCESS cycle of a p1 write.
    set_port(1, 1, 1, 4'd7, 4'h5);
    n = 0;
    do begin step(); n++; end while (!exp_gnt[1] && n < 10);
    check_eq("mid_cw_before", mem_control_write, 1'b1);
    reset = 1'b1;
    #1;
    check_eq("mid_cw_now", mem_control_write, 1'b0);
    check_eq("mid_gnt_now", {p1_gnt, p0_gnt}, 2'b00);
    set_port(1, 0, 0, '0, '0);
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    check_eq("mid_rdata", {p1_rdata, p0_rdata}, '0);
    repeat (2) step();
    set_port(0, 1, 0, 4'd7, '0);
    set_port(1, 1, 0, 4'd7, '0);
    step();
    check_eq("mid_tie_p0", {p1_gnt, p0_gnt}, 2'b01);
    set_port(0, 0, 0, '0, '0);
    step();
    check_eq("mid_no_write", p0_rdata, 4'h0);
    set_port(1, 0, 0, '0, '0);
    repeat (4) step();

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      for (int p = 0; p < 2; p++) begin
        bit cur;
        cur = p[0] ? p1_req : p0_req;
        if (exp_gnt[p]) begin
          if ($urandom_range(1, 0) == 1)
            set_port(p[0], 1, 1'($urandom), 4'($urandom), 4'($urandom));
          else
            set_port(p[0], 0, 0, '0, '0);
        end else if (!cur && $urandom_range(2, 0) == 0) begin
          set_port(p[0], 1, 1'($urandom), 4'($urandom), 4'($urandom));
        end
      end
      step();
    end
    set_port(0, 0, 0, '0, '0);
    set_port(1, 0, 0, '0, '0);
    repeat (6) step();

`ifdef DATA_MEMORY_ARBITER_STATS_EN
    do_reset();
    check_eq("cnt_rst", {p1_grant_count, p0_grant_count}, '0);
    for (int k = 0; k < 5; k++) do_req(0, 0, 4'(k), '0, lat);
    for (int k = 0; k < 2; k++) do_req(1, 0, 4'(k), '0, lat);
    check_eq("cnt_p0", p0_grant_count, 5);
    check_eq("cnt_p1", p1_grant_count, 2);
    set_port(0, 1, 0, 4'd1, '0);
    n = 0;
    do begin step(); n++; end while (!exp_gnt[0] && n < 10);
    set_port(0, 0, 0, '0, '0);
    stats_clear = 1'b1;
    step();
    stats_clear = 1'b0;
    check_eq("cnt_clr_p0", p0_grant_count, 0);
    check_eq("cnt_clr_p1", p1_grant_count, 0);
    repeat (2) step();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired got=running exp=finished");
    $fatal(1);
  end

endmodule
